pipe_stage_skid: RTL

Parametrised pipeline stage register for the MIPS datapath. It replaces fixed per-stage latches with a valid/ready stage that has:
- a 2-entry skid buffer, synchronous flush and bubble gating of side-effect control bits;
- capture-time transforms: exception vector override of the ALU result, and PC = PC+4 − 4;
- a saturating stall counter.

It is instantiated between EX and MEM first, then reused for the other stage boundaries.

---
 rtl/pipe_stage_skid_if.sv | 47 ++++
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready link around one pipe_stage_skid: upstream entry, downstream head,
// synchronous flush and the stall counter readout.
interface pipe_stage_skid_if #(
    parameter int DW     = 32,
    parameter int RF_W   = 5,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) ();
    logic              flush;

    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     alu_res_i;
    logic [DW-1:0]     op2_i;
    logic [DW-1:0]     pcp4_i;
    logic [DW-1:0]     ins_i;
    logic [RF_W-1:0]   rf_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              exc_i;

    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     alu_res_o;
    logic [DW-1:0]     op2_o;
    logic [DW-1:0]     pc_o;
    logic [DW-1:0]     ins_o;
    logic [RF_W-1:0]   rf_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic              exc_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    // Surrounding pipeline: feeds entries, consumes the head.
    modport master (
        output flush, in_valid, alu_res_i, op2_i, pcp4_i, ins_i, rf_i, ctrl_i, exc_i,
        output out_ready,
        input  in_ready, out_valid, alu_res_o, op2_o, pc_o, ins_o, rf_o, ctrl_o, exc_o,
        input  stall_cnt_o
    );

    // The stage itself.
    modport slave (
        input  flush, in_valid, alu_res_i, op2_i, pcp4_i, ins_i, rf_i, ctrl_i, exc_i,
        input  out_ready,
        output in_ready, out_valid, alu_res_o, op2_o, pc_o, ins_o, rf_o, ctrl_o, exc_o,
        output stall_cnt_o
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// MIPS pipeline stage register with a 2-entry skid buffer, flush, bubble gating
// of side-effect control bits, capture-time transforms and a stall counter.
module pipe_stage_skid #(
    parameter int              DW         = 32,
    parameter int              RF_W       = 5,
    parameter int              CTRL_W     = 10,
    parameter logic [CTRL_W-1:0] GATE_MASK  = 10'h023,
    parameter logic [DW-1:0]   EXC_VECTOR = 32'h40000010,
    parameter int              CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_stage_skid_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0]     alu_res;
        logic [DW-1:0]     op2;
        logic [DW-1:0]     pc;
        logic [DW-1:0]     ins;
        logic [RF_W-1:0]   rf;
        logic [CTRL_W-1:0] ctrl;
        logic              exc;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           main_q, skid_q, in_entry;
    logic [CNT_W-1:0] stall_cnt_q;

    logic in_ready, out_valid;
    logic accept, pop;
    logic load_main_in, load_skid_in, load_main_skid;

    assign accept = bus.in_valid & in_ready & ~bus.flush;
    assign pop    = out_valid & bus.out_ready;

    // Capture transform: exception vector replaces the ALU result, and the
    // incoming PC+4 is turned back into the instruction's own PC.
    always_comb begin
        in_entry.alu_res = bus.exc_i ? EXC_VECTOR : bus.alu_res_i;
        in_entry.op2     = bus.op2_i;
        in_entry.pc      = bus.pcp4_i - DW'(4);
        in_entry.ins     = bus.ins_i;
        in_entry.rf      = bus.rf_i;
        in_entry.ctrl    = bus.ctrl_i;
        in_entry.exc     = bus.exc_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // NOTE: every output of a combinational process gets a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = ST_FULL;
                    load_skid_in = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over everything; a same-cycle pop has still been seen downstream.
        if (bus.flush) state_d = ST_EMPTY;
    end

    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
    end

    // NOTE: the two payload entries are reset to zero so the outputs are defined
    // (pc_o, alu_res_o, ctrl_o all 0) from the moment reset asserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid_in)        skid_q <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.alu_res_o   = main_q.alu_res;
    assign bus.op2_o       = main_q.op2;
    assign bus.pc_o        = main_q.pc;
    assign bus.ins_o       = main_q.ins;
    assign bus.rf_o        = main_q.rf;
    // Bubbles must not carry MemWr/MemRd/RegWr-style side effects downstream.
    assign bus.ctrl_o      = out_valid ? main_q.ctrl : (main_q.ctrl & ~GATE_MASK);
    assign bus.exc_o       = main_q.exc & out_valid;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule
